speed_tick_gen: RTL and testbench

Timebase generator for the car game. It divides `CLOCK_50` into three phase-aligned, single-cycle enable strobes: eighth-second, quarter-second and half-second. These are the `ESecEn`, `QSecEn` and `HSecEn` inputs that the speed-select stage consumes. The block also provides synchronous pause and restart, so game logic can freeze or re-align the car's motion timebase.

---
 rtl/speed_tick_gen.sv | 105 ++++++++++
 tb/tb_speed_tick_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/speed_tick_gen.sv
// ============================================================================
//  Module   : speed_tick_gen
//  Brief    : Eighth/quarter/half-second phase-aligned enable strobes with
//             synchronous pause/restart. Optional TickCount port is built in
//             with SPEED_TICK_COUNT_EN defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module speed_tick_gen #(
   parameter int TICK_CYCLES = 6250000,
   parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
   input  logic        CLOCK_50,
   input  logic        Resetn,
   input  logic        Pause,
   input  logic        Restart,
   output logic        ESecEn,
   output logic        QSecEn,
`ifdef SPEED_TICK_COUNT_EN
   output logic        HSecEn,
   output logic [15:0] TickCount
`else
   output logic        HSecEn
`endif
);

   localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic             esec_q,  esec_d;
   logic             qsec_q,  qsec_d;
   logic             hsec_q,  hsec_d;
   logic             w_tick;
`ifdef SPEED_TICK_COUNT_EN
   logic [15:0]      tcnt_q,  tcnt_d;
`endif

   // A paused tick edge leaves cnt_q at 0, so the tick fires on the first free edge.
   assign w_tick = (cnt_q == '0);

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      esec_d  = 1'b0;
      qsec_d  = 1'b0;
      hsec_d  = 1'b0;
`ifdef SPEED_TICK_COUNT_EN
      tcnt_d  = tcnt_q;
`endif
      if (Restart) begin
         cnt_d   = c_RELOAD;
         phase_d = 2'd0;
`ifdef SPEED_TICK_COUNT_EN
         tcnt_d  = 16'd0;
`endif
      end else if (Pause) begin
         cnt_d   = cnt_q;
      end else if (!w_tick) begin
         cnt_d   = cnt_q - CNT_W'(1);
      end else begin
         cnt_d   = c_RELOAD;
         phase_d = phase_q + 2'd1;
         esec_d  = 1'b1;
         qsec_d  = phase_q[0];
         hsec_d  = (phase_q == 2'd3);
`ifdef SPEED_TICK_COUNT_EN
         tcnt_d  = tcnt_q + 16'd1;
`endif
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         cnt_q   <= c_RELOAD;
         phase_q <= 2'd0;
         esec_q  <= 1'b0;
         qsec_q  <= 1'b0;
         hsec_q  <= 1'b0;
`ifdef SPEED_TICK_COUNT_EN
         tcnt_q  <= 16'd0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         esec_q  <= esec_d;
         qsec_q  <= qsec_d;
         hsec_q  <= hsec_d;
`ifdef SPEED_TICK_COUNT_EN
         tcnt_q  <= tcnt_d;
`endif
      end
   end

   assign ESecEn    = esec_q;
   assign QSecEn    = qsec_q;
   assign HSecEn    = hsec_q;
`ifdef SPEED_TICK_COUNT_EN
   assign TickCount = tcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_speed_tick_gen.sv
// ============================================================================
//  Module   : tb_speed_tick_gen
//  Brief    : Table-driven bench for speed_tick_gen with TICK_CYCLES = 4.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_speed_tick_gen;

   localparam int TICK = 4;

   logic        CLOCK_50;
   logic        Resetn;
   logic        Pause;
   logic        Restart;
   logic        ESecEn;
   logic        QSecEn;
   logic        HSecEn;
`ifdef SPEED_TICK_COUNT_EN
   logic [15:0] TickCount;
`endif

   speed_tick_gen #(.TICK_CYCLES(TICK)) dut (
      .CLOCK_50  (CLOCK_50),
      .Resetn    (Resetn),
      .Pause     (Pause),
      .Restart   (Restart),
      .ESecEn    (ESecEn),
      .QSecEn    (QSecEn),
`ifdef SPEED_TICK_COUNT_EN
      .HSecEn    (HSecEn),
      .TickCount (TickCount)
`else
      .HSecEn    (HSecEn)
`endif
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic pause;
      logic restart;
      logic e;
      logic q;
      logic h;
   } vec_t;

   typedef struct {
      logic [2:0] eqh;
      int         edge_n;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic add(input logic p, input logic r, input logic e, input logic q, input logic h);
      vec_t v;
      v.pause = p; v.restart = r; v.e = e; v.q = q; v.h = h;
      tbl.push_back(v);
   endtask

   // Starts and ends at a falling edge; row i drives edge i+1.
   task automatic apply_table(input string name);
      exp_t x;
      exp_t got;
      for (int i = 0; i < tbl.size(); i++) begin
         Pause   = tbl[i].pause;
         Restart = tbl[i].restart;
         x.eqh    = {tbl[i].e, tbl[i].q, tbl[i].h};
         x.edge_n = i + 1;
         sb.push_back(x);
         @(posedge CLOCK_50);
         #1;
         got = sb.pop_front();
         checks++;
         if ({ESecEn, QSecEn, HSecEn} !== got.eqh) begin
            failures++;
            $display("FAIL %s edge %0d: got EQH=%b, expected %b",
                     name, got.edge_n, {ESecEn, QSecEn, HSecEn}, got.eqh);
         end
         @(negedge CLOCK_50);
      end
      Pause   = 1'b0;
      Restart = 1'b0;
      tbl.delete();
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      Resetn  = 1'b0;
      Pause   = 1'b0;
      Restart = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      check("reset_strobes", int'({ESecEn, QSecEn, HSecEn}), 0);
      Resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Resetn  = 1'b0;
      Pause   = 1'b0;
      Restart = 1'b0;
      #2;
      check("async_reset_initial", int'({ESecEn, QSecEn, HSecEn}), 0);
      do_reset();

      // Free run: E every 4 edges, Q every 8, H every 16.
      for (int n = 1; n <= 16; n++)
         add(0, 0, (n % 4) == 0, (n % 8) == 0, (n % 16) == 0);
      apply_table("free_run");
`ifdef SPEED_TICK_COUNT_EN
      check("tickcount_after_4_ticks", int'(TickCount), 4);
`endif

      // Async reset mid-cycle while HSecEn is still high from edge 16.
      check("hsec_high_before_reset", int'(HSecEn), 1);
      Resetn = 1'b0;
      #1;
      check("async_reset_drop", int'({ESecEn, QSecEn, HSecEn}), 0);
`ifdef SPEED_TICK_COUNT_EN
      check("async_reset_tickcount", int'(TickCount), 0);
`endif
      @(negedge CLOCK_50);
      Resetn = 1'b1;

      // Restart on edge 6 after one tick: phase realigns.
      for (int n = 1; n <= 14; n++)
         add(0, n == 6, (n == 4) || (n == 10) || (n == 14), n == 14, 0);
      apply_table("restart_edge6");

      // Pause over edges 3..12: deferred tick at 14, then 18 with Q.
      do_reset();
      for (int n = 1; n <= 20; n++)
         add((n >= 3) && (n <= 12), 0, (n == 14) || (n == 18), n == 18, 0);
      apply_table("pause_3_12");
`ifdef SPEED_TICK_COUNT_EN
      check("tickcount_after_pause_run", int'(TickCount), 2);
`endif
      for (int n = 1; n <= 5; n++) add(1, 0, 0, 0, 0);
      apply_table("pause_hold");
`ifdef SPEED_TICK_COUNT_EN
      check("tickcount_pause_hold", int'(TickCount), 2);
`endif
      add(1, 1, 0, 0, 0);
      for (int n = 2; n <= 5; n++) add(0, 0, n == 5, 0, 0);
      apply_table("restart_during_pause");
`ifdef SPEED_TICK_COUNT_EN
      check("tickcount_after_restart", int'(TickCount), 1);
`endif

      // Restart+Pause on edge 2, Pause alone on 3..4: first E after edge 8.
      do_reset();
      for (int n = 1; n <= 16; n++)
         add((n >= 2) && (n <= 4), n == 2, (n == 8) || (n == 12) || (n == 16), n == 12, 0);
      apply_table("restart_and_pause");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
